operand_feeder: RTL and testbench
=================================

Name: operand_feeder

Overview:
- Upstream stage of the approximate 16x16 multiplier (normalise-shift / 8x8 multiply / re-shift datapath plus its controller).
- Buffers operand pairs from a valid/ready producer in a small circular FIFO.
- Launches the multiplier core one pair at a time with a start pulse, and holds both operands stable until the core reports done.
- Pops the entry on done, then immediately launches the next pair if one is queued.

Parameters:
- WIDTH, 16, operand width; must equal the core's in1/in2 width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 2, log2(DEPTH).
- TIMEOUT, 64, watchdog limit in cycles; used only when OPERAND_FEEDER_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a pair on in_a/in_b.
- in_ready  out  1  equals !full; a word is accepted on an edge where in_valid && in_ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- core_start  out  1  one-cycle launch pulse to the multiplier controller.
- core_done  in  1  one-cycle completion pulse from the multiplier controller.
- core_in1  out  WIDTH  operand A held for the core.
- core_in2  out  WIDTH  operand B held for the core.
- busy  out  1  high while state != IDLE.
- count  out  ADDR_W+1  number of occupied entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- timeout_err  out  1  sticky watchdog flag; tied 0 unless the macro is defined.

Behaviour:
- Reset (rst high at an edge):
  - wr_ptr = rd_ptr = 0, count = 0, state = IDLE.
  - core_start = 0, core_in1 = core_in2 = 0, timeout_err = 0.
  - Reset wins over a simultaneous push or done; a push in the reset cycle is discarded.
- After reset: empty = 1, full = 0, in_ready = 1.
- Push: on in_valid && in_ready, write {in_a, in_b} to mem[wr_ptr]; wr_ptr increments mod DEPTH and wraps from DEPTH-1 to 0.
- Pop: happens only on the WAIT->next transition triggered by core_done; rd_ptr increments mod DEPTH.
- Push and pop in the same edge: count unchanged; both pointers advance.
- When full, in_ready = 0 even if a pop occurs in that cycle; there is no same-cycle pass-through.
- FSM states, registered: IDLE, LAUNCH, WAIT.
  - IDLE: if !empty, go to LAUNCH and load core_in1/core_in2 from mem[rd_ptr] on that edge. Otherwise stay in IDLE.
  - LAUNCH: core_start = 1 for exactly this cycle; next state is WAIT unconditionally.
  - WAIT: core_in1/core_in2 hold. On core_done, pop.
    - If count after the pop is > 0, go to LAUNCH and load the new head on the same edge.
    - Otherwise go to IDLE.
- core_done is ignored in IDLE and LAUNCH.
- core_in1/core_in2 change only on an edge that enters LAUNCH.
- Latency, empty and idle: word accepted at edge E0, LAUNCH entered at E1, core_start high in the cycle after E1.
- Back-to-back launch: done sampled at edge Ed, core_start high in the cycle after Ed; the core loses no cycle.
- Reset mid-operation: the queue is flushed and the in-flight pair is abandoned. The core is reset by the same rst.

Optional Feature:
- Macro: OPERAND_FEEDER_TIMEOUT_EN.
- Defined:
  - A cycle counter (width clog2(TIMEOUT+1)) clears on LAUNCH and increments in WAIT.
  - If it reaches TIMEOUT with no core_done, timeout_err is set (sticky until rst). The head is popped as if done had arrived and the FSM proceeds normally.
  - A core_done in the same cycle takes priority: no error.
- Undefined: no counter; timeout_err = 0 constantly; WAIT lasts indefinitely.

Decomposition:
- Shared package: FSM state encoding localparams (IDLE=2'd0, LAUNCH=2'd1, WAIT=2'd2), default WIDTH/DEPTH constants.
- Sub-module operand_fifo_mem:
  - Contains the DEPTH x 2*WIDTH register array, pointers, count, full and empty.
  - Interface: push/pop strobes plus head read data.
  - The top level holds the FSM, operand hold registers and watchdog.

Test Plan:
- Reset then idle → in_ready=1, empty=1, count=0, core_start never asserts over 20 cycles.
- Push (0x00F3, 0x1A00); done 12 cycles after start → start one cycle after entering LAUNCH; core_in1=0x00F3, core_in2=0x1A00 stable until done; afterwards count=0, busy=0.
- Push 5 pairs back-to-back with core_done never asserted → the first pair launches and leaves the queue only on done; count saturates at 4 with full=1, in_ready=0; the 5th pair is held by the producer and accepted after the first done.
- Queue 3 pairs and pulse done each time → launches follow done with zero idle cycles; operands appear in FIFO order; pointer wrap verified with 6 total pairs.
- rst asserted in WAIT with count=3 → next cycle count=0, state IDLE, core_in1/core_in2=0, core_start=0.
- With OPERAND_FEEDER_TIMEOUT_EN, TIMEOUT=8, no done → timeout_err rises 8 cycles after LAUNCH; the head is popped and the next pair launches. Without the macro → timeout_err stays 0.

Source files
------------

// File: rtl/operand_feeder_pkg.sv
// Shared definitions for the operand feeder and its FIFO storage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package operand_feeder_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_ADDR_W  = 2;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

endpackage

// File: rtl/operand_fifo_mem.sv
// Circular FIFO holding {A,B} operand pairs; exposes the head and the entry after it.
// Latency: a pushed word is visible at the head one edge after the push when the queue was empty.
// Backpressure: push is ignored when full, pop is ignored when empty; the caller gates both.
//
// Ports: clk/rst (sync, active-high); push/push_dat write strobe and data;
//        pop advances the read pointer; head_dat = mem[rd_ptr], next_dat = mem[rd_ptr+1];
//        count/full/empty occupancy.
import operand_feeder_pkg::*;

module operand_fifo_mem #(
    parameter int DW     = 2 * DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DW-1:0]     push_dat,
    input  logic              pop,
    output logic [DW-1:0]     head_dat,
    output logic [DW-1:0]     next_dat,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    logic [DW-1:0]     r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] w_rd_nxt;
    logic              w_push;
    logic              w_pop;

    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    // DEPTH is a power of two, so pointer overflow is the wrap.
    assign w_rd_nxt = r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= w_rd_nxt;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) r_mem[r_wr_ptr] <= push_dat;
    end

    assign head_dat = r_mem[r_rd_ptr];
    assign next_dat = r_mem[w_rd_nxt];
    assign count    = r_count;
    assign full     = (r_count == (ADDR_W+1)'(DEPTH));
    assign empty    = (r_count == '0);

endmodule

// File: rtl/operand_feeder.sv
// Queues operand pairs and launches the multiplier core one pair at a time, holding operands until done.
// Latency: push at E0 -> LAUNCH at E1 -> core_start high the cycle after E1; relaunch right after done.
// Backpressure: in_ready = !full (registered occupancy), no same-cycle pass-through on a pop.
//
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_a/in_b producer side;
//        core_start/core_done/core_in1/core_in2 multiplier side;
//        busy/count/full/empty status; timeout_err sticky watchdog flag.
// Optional watchdog: define OPERAND_FEEDER_TIMEOUT_EN; otherwise timeout_err is tied 0.
import operand_feeder_pkg::*;

module operand_feeder #(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              core_start,
    input  logic              core_done,
    output logic [WIDTH-1:0]  core_in1,
    output logic [WIDTH-1:0]  core_in2,
    output logic              busy,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              timeout_err
);

    if (DEPTH != (1 << ADDR_W) || DEPTH < 2 || TIMEOUT < 1) begin : g_bad_cfg
        $error("operand_feeder: inconsistent DEPTH/ADDR_W/TIMEOUT");
    end

    state_t              r_state;
    logic                r_core_start;
    logic [WIDTH-1:0]    r_core_in1;
    logic [WIDTH-1:0]    r_core_in2;

    logic [2*WIDTH-1:0]  w_push_dat;
    logic [2*WIDTH-1:0]  w_head_dat;
    logic [2*WIDTH-1:0]  w_next_dat;
    logic [2*WIDTH-1:0]  w_relaunch_dat;
    logic                w_push;
    logic                w_done;
    logic                w_pop;
    logic                w_relaunch;
    logic                w_multi;

    assign w_push_dat = {in_a, in_b};
    assign in_ready   = !full;
    assign w_push     = in_valid && !full;

`ifdef OPERAND_FEEDER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout_err;
    logic            w_wd_fire;

    // A real done in the same cycle wins, so the flag only marks genuine stalls.
    assign w_wd_fire = (r_state == WAIT) && !core_done && (r_wd_cnt == WD_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == LAUNCH)
                r_wd_cnt <= '0;
            else if (r_state == WAIT && r_wd_cnt != WD_W'(TIMEOUT))
                r_wd_cnt <= r_wd_cnt + 1'b1;
            if (w_wd_fire) r_timeout_err <= 1'b1;
        end
    end

    assign w_done      = core_done || w_wd_fire;
    assign timeout_err = r_timeout_err;
`else
    assign w_done      = core_done;
    assign timeout_err = 1'b0;
`endif

    assign w_pop = (r_state == WAIT) && w_done;

    // After the pop the new head is the second stored entry, or, if only the
    // in-flight pair was stored, the word being pushed on this very edge.
    assign w_multi        = (count > (ADDR_W+1)'(1));
    assign w_relaunch     = w_pop && (w_multi || w_push);
    assign w_relaunch_dat = w_multi ? w_next_dat : w_push_dat;

    operand_fifo_mem #(
        .DW     (2 * WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .push_dat (w_push_dat),
        .pop      (w_pop),
        .head_dat (w_head_dat),
        .next_dat (w_next_dat),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_core_start <= 1'b0;
            r_core_in1   <= '0;
            r_core_in2   <= '0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!empty) begin
                        r_state      <= LAUNCH;
                        r_core_start <= 1'b1;
                        r_core_in1   <= w_head_dat[2*WIDTH-1:WIDTH];
                        r_core_in2   <= w_head_dat[WIDTH-1:0];
                    end
                end
                LAUNCH: r_state <= WAIT;
                WAIT: begin
                    if (w_relaunch) begin
                        r_state      <= LAUNCH;
                        r_core_start <= 1'b1;
                        r_core_in1   <= w_relaunch_dat[2*WIDTH-1:WIDTH];
                        r_core_in2   <= w_relaunch_dat[WIDTH-1:0];
                    end else if (w_pop) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign core_start = r_core_start;
    assign core_in1   = r_core_in1;
    assign core_in2   = r_core_in2;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder: inputs driven and outputs sampled on the falling edge.
module tb_operand_feeder;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int AW = 2;
`ifdef OPERAND_FEEDER_TIMEOUT_EN
    localparam int HOLD = 5;
`else
    localparam int HOLD = 11;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          core_start;
    logic          core_done;
    logic [W-1:0]  core_in1;
    logic [W-1:0]  core_in2;
    logic          busy;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] pa [5] = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005};
    logic [W-1:0] pb [5] = '{16'hA00A, 16'hB00B, 16'hC00C, 16'hD00D, 16'hE00E};
    logic [W-1:0] qa [6] = '{16'hC000, 16'hC111, 16'hC222, 16'hC333, 16'hC444, 16'hC555};
    logic [W-1:0] qb [6] = '{16'h0FF0, 16'h0FEF, 16'h0FEE, 16'h0FED, 16'h0FEC, 16'h0FEB};

    operand_feeder #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_in1    (core_in1),
        .core_in2    (core_in2),
        .busy        (busy),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic seen;
        logic stable;

        rst = 1'b1; in_valid = 1'b0; core_done = 1'b0; in_a = '0; in_b = '0;
        repeat (2) tick();

        // Reset state
        chk("rst_ready", in_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in1", core_in1, 0);
        chk("rst_in2", core_in2, 0);
        chk("rst_start", core_start, 0);
        chk("rst_terr", timeout_err, 0);
        rst = 1'b0;

        seen = 1'b0;
        repeat (20) begin
            tick();
            if (core_start) seen = 1'b1;
        end
        chk("idle_no_start", seen, 0);

        // Single pair, done well after the launch
        in_valid = 1'b1; in_a = 16'h00F3; in_b = 16'h1A00;
        tick();
        in_valid = 1'b0;
        chk("t2_count", count, 1);
        chk("t2_nostart", core_start, 0);
        tick();
        chk("t2_start", core_start, 1);
        chk("t2_in1", core_in1, 16'h00F3);
        chk("t2_in2", core_in2, 16'h1A00);
        chk("t2_busy", busy, 1);
        stable = 1'b1;
        repeat (HOLD) begin
            tick();
            if (core_start || core_in1 != 16'h00F3 || core_in2 != 16'h1A00) stable = 1'b0;
        end
        chk("t2_stable", stable, 1);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("t2_cnt0", count, 0);
        chk("t2_idle", busy, 0);
        chk("t2_hold_after", core_in1, 16'h00F3);

        // Fill to full with no done; fifth pair must be held back
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = pa[i]; in_b = pb[i];
            tick();
        end
        in_a = pa[4]; in_b = pb[4];
        chk("t3_count4", count, 4);
        chk("t3_full", full, 1);
        chk("t3_notready", in_ready, 0);
        chk("t3_head", core_in1, pa[0]);
        repeat (5) tick();
        chk("t3_still4", count, 4);
        chk("t3_held", in_ready, 0);
        chk("t3_head2", core_in1, pa[0]);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("t3_relaunch", core_start, 1);
        chk("t3_in1_p1", core_in1, pa[1]);
        chk("t3_in2_p1", core_in2, pb[1]);
        chk("t3_count3", count, 3);
        chk("t3_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t3_p4_in", count, 4);
        chk("t3_pulse1", core_start, 0);
        for (int k = 2; k < 5; k++) begin
            core_done = 1'b1;
            tick();
            core_done = 1'b0;
            chk("t3_start_k", core_start, 1);
            chk("t3_in1_k", core_in1, pa[k]);
            chk("t3_in2_k", core_in2, pb[k]);
            tick();
            chk("t3_pulse_k", core_start, 0);
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("t3_drained", count, 0);
        chk("t3_idle", busy, 0);

        // Two batches of three, done pulsed each time, zero-gap relaunch
        for (int bt = 0; bt < 2; bt++) begin
            for (int j = 0; j < 3; j++) begin
                in_valid = 1'b1; in_a = qa[bt*3+j]; in_b = qb[bt*3+j];
                tick();
            end
            in_valid = 1'b0;
            chk("t4_first", core_in1, qa[bt*3]);
            chk("t4_count3", count, 3);
            for (int j = 1; j < 3; j++) begin
                core_done = 1'b1;
                tick();
                core_done = 1'b0;
                chk("t4_start", core_start, 1);
                chk("t4_in1", core_in1, qa[bt*3+j]);
                chk("t4_in2", core_in2, qb[bt*3+j]);
                tick();
                chk("t4_pulse", core_start, 0);
            end
            core_done = 1'b1;
            tick();
            core_done = 1'b0;
            chk("t4_empty", empty, 1);
            chk("t4_idle", busy, 0);
        end

        // done during LAUNCH is ignored; pop+push on one edge relaunches the pushed word
        in_valid = 1'b1; in_a = 16'h7E57; in_b = 16'h0042;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t4b_launch", core_start, 1);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("t4b_ign_cnt", count, 1);
        chk("t4b_ign_busy", busy, 1);
        core_done = 1'b1; in_valid = 1'b1; in_a = 16'hBEEF; in_b = 16'h0123;
        tick();
        core_done = 1'b0; in_valid = 1'b0;
        chk("t4b_start", core_start, 1);
        chk("t4b_in1", core_in1, 16'hBEEF);
        chk("t4b_in2", core_in2, 16'h0123);
        chk("t4b_count", count, 1);
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("t4b_idle", busy, 0);

        // Reset in WAIT with three queued; simultaneous push discarded
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1; in_a = pa[j]; in_b = pb[j];
            tick();
        end
        in_a = 16'hDEAD; in_b = 16'hDEAD;
        chk("t5_pre_cnt", count, 3);
        chk("t5_pre_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("t5_count", count, 0);
        chk("t5_busy", busy, 0);
        chk("t5_in1", core_in1, 0);
        chk("t5_in2", core_in2, 0);
        chk("t5_start", core_start, 0);
        chk("t5_empty", empty, 1);
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (core_start) seen = 1'b1;
        end
        chk("t5_flushed", seen, 0);

        // Stalled core: watchdog behaviour
        in_valid = 1'b1; in_a = pa[0]; in_b = pb[0];
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
`ifdef OPERAND_FEEDER_TIMEOUT_EN
        chk("t6_terr", timeout_err, 1);
        chk("t6_popped", count, 0);
        chk("t6_idle", busy, 0);
`else
        chk("t6_terr", timeout_err, 0);
        chk("t6_waiting", busy, 1);
        chk("t6_kept", count, 1);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("t6_idle", busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
